// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package muldiv_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, RUN, WB, EXC} state_e;

  localparam logic OP_MULT      = 1'b0;
  localparam logic OP_DIV       = 1'b1;
  localparam int   ITER_DEFAULT = 32;
endpackage

// File: rtl/muldiv_if.sv
// ctrl_unit <-> sequencer handshake: request, operand for the zero test, status back.
interface muldiv_if;
  logic        start;
  logic        op;
  logic [31:0] divisor;
  logic        abort;
  logic        mult_rest_zero;
  logic        busy;
  logic        done;
  logic        div_zero_exc;

  modport master (output start, op, divisor, abort, mult_rest_zero,
                  input  busy, done, div_zero_exc);
  modport slave  (input  start, op, divisor, abort, mult_rest_zero,
                  output busy, done, div_zero_exc);
endinterface

// File: rtl/muldiv_iter_cnt.sv
// Iteration counter: clear loads zero, en counts up, last flags the final iteration.
module muldiv_iter_cnt #(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(ITER - 1));
endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared iterative mult/div unit: IDLE -> CHECK -> RUN x ITER -> WB (or EXC).
// Define MULDIV_EARLY_OUT_EN to let mult_rest_zero end a MULT run early.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITER  = ITER_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus,
  output logic     unit_clear,
  output logic     mult_en,
  output logic     div_en,
  output logic     sel_mult_or_div,
  output logic     hi_w,
  output logic     lo_w
);
  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   cnt_last;
  logic   early_out;

  muldiv_iter_cnt #(.ITER(ITER), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == CHECK),
    .en    (state_q == RUN),
    .last  (cnt_last)
  );

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (op_q == OP_MULT) && bus.mult_rest_zero;
`else
  logic unused_mult_rest_zero;
  assign unused_mult_rest_zero = bus.mult_rest_zero;
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (bus.start) begin
        op_d    = bus.op;
        state_d = CHECK;
      end
      CHECK: begin
        if (bus.abort)                                   state_d = IDLE;
        else if (op_q == OP_DIV && bus.divisor == '0)    state_d = EXC;
        else                                             state_d = RUN;
      end
      // abort wins over the final-iteration exit
      RUN: begin
        if (bus.abort)                  state_d = IDLE;
        else if (cnt_last || early_out) state_d = WB;
      end
      WB, EXC: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    unit_clear      = (state_q == CHECK);
    mult_en         = (state_q == RUN) && (op_q == OP_MULT);
    div_en          = (state_q == RUN) && (op_q == OP_DIV);
    sel_mult_or_div = op_q;
    hi_w            = (state_q == WB);
    lo_w            = (state_q == WB);
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == WB) || (state_q == EXC);
  assign bus.div_zero_exc = (state_q == EXC);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Table-driven plus randomized check of muldiv_sequencer against a cycle-count outcome model.
module tb_muldiv_sequencer;
  localparam int ITER    = 32;
  localparam int K_ABORT = 0;
  localparam int K_WB    = 1;
  localparam int K_EXC   = 2;

  logic clk = 1'b0;
  logic reset;
  logic unit_clear, mult_en, div_en, sel_mult_or_div, hi_w, lo_w;
  muldiv_if bus();

  muldiv_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .unit_clear      (unit_clear),
    .mult_en         (mult_en),
    .div_en          (div_en),
    .sel_mult_or_div (sel_mult_or_div),
    .hi_w            (hi_w),
    .lo_w            (lo_w)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  logic prev_op  = 1'b0;

  typedef struct {
    logic        op;
    logic [31:0] dv;
    int          ab;     // cycle abort is high (0 = never)
    int          mrz;    // cycle mult_rest_zero is high (0 = never)
    bit          noise;  // stray start pulses while busy
    int          e;      // expected last busy cycle
    int          kind;
  } vec_t;

  vec_t tbl[12];

  // {busy, unit_clear, mult_en, div_en, sel, hi_w, lo_w, done, div_zero_exc}
  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {bus.busy, unit_clear, mult_en, div_en, sel_mult_or_div,
           hi_w, lo_w, bus.done, bus.div_zero_exc};
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (busy,clr,men,den,sel,hi,lo,done,exc)",
               name, act, exp);
    end
  endtask

  // Outcome from the rules: fixed ITER+2 busy cycles, 2 for div-by-zero,
  // optional early exit, then truncation by an abort in CHECK/RUN.
  task automatic model(input logic op, input logic [31:0] dv, input int ab,
                       input int mrz, output int e, output int kind);
    if (op && dv == 0) begin
      e = 2; kind = K_EXC;
    end else begin
      e = ITER + 2; kind = K_WB;
`ifdef MULDIV_EARLY_OUT_EN
      if (!op && mrz >= 2 && mrz < e) e = mrz + 1;
`endif
    end
    if (ab >= 1 && ab < e) begin
      e = ab; kind = K_ABORT;
    end
  endtask

  // Cycle 0 presents start in IDLE; cycles 1..e are the busy cycles.
  task automatic run_op(input string name, input logic op, input logic [31:0] dv,
                        input int ab, input int mrz, input bit noise,
                        input int e, input int kind);
    logic [8:0] exp;
    bit run, endc;
    for (int c = 0; c <= e; c++) begin
      bus.start          = (c == 0) || (noise && ($urandom_range(0, 2) == 0));
      bus.op             = (c == 0) ? op : 1'($urandom_range(0, 1));
      bus.divisor        = (c == 1) ? dv : $urandom;
      bus.abort          = (c >= 1) && (c == ab);
      bus.mult_rest_zero = (c >= 1) && (c == mrz);
      @(negedge clk);
      if (c == 0) begin
        exp = {4'b0000, prev_op, 4'b0000};
      end else begin
        run  = (kind == K_ABORT) ? (c >= 2) : (kind == K_WB && c >= 2 && c < e);
        endc = (c == e) && (kind != K_ABORT);
        exp  = {1'b1, c == 1, run && !op, run && op, op,
                endc && kind == K_WB, endc && kind == K_WB, endc, endc && kind == K_EXC};
      end
      check($sformatf("%s c%0d", name, c), exp);
      @(posedge clk); #1;
    end
    prev_op            = op;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.mult_rest_zero = 1'b0;
  endtask

  initial begin
    int e, kind, ab, mrz;
    logic op;
    logic [31:0] dv;

    tbl[0]  = '{1'b0, 32'd7,          0,  0, 1'b0, 34, K_WB};
    tbl[1]  = '{1'b1, 32'd3,          0,  0, 1'b0, 34, K_WB};
    tbl[2]  = '{1'b1, 32'd0,          0,  0, 1'b0,  2, K_EXC};
    tbl[3]  = '{1'b0, 32'd9,         12,  0, 1'b0, 12, K_ABORT};
    tbl[4]  = '{1'b1, 32'd1,          0,  0, 1'b1, 34, K_WB};
    tbl[5]  = '{1'b0, 32'd0,          0,  0, 1'b1, 34, K_WB};
`ifdef MULDIV_EARLY_OUT_EN
    tbl[6]  = '{1'b0, 32'd4,          0,  7, 1'b0,  8, K_WB};
`else
    tbl[6]  = '{1'b0, 32'd4,          0,  7, 1'b0, 34, K_WB};
`endif
    tbl[7]  = '{1'b1, 32'd0,          1,  0, 1'b0,  1, K_ABORT};
    tbl[8]  = '{1'b1, 32'd0,          2,  0, 1'b0,  2, K_EXC};
    tbl[9]  = '{1'b1, 32'hFFFF_FFFF, 34,  0, 1'b0, 34, K_WB};
    tbl[10] = '{1'b1, 32'd2,         33,  0, 1'b0, 33, K_ABORT};
    tbl[11] = '{1'b1, 32'd6,          0, 10, 1'b0, 34, K_WB};

    bus.start = 1'b0; bus.op = 1'b0; bus.divisor = '0;
    bus.abort = 1'b0; bus.mult_rest_zero = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", 9'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].dv, tbl[i].ab, tbl[i].mrz,
             tbl[i].noise, tbl[i].e, tbl[i].kind);

    // reset in the middle of a DIV run clears op_q and suppresses writeback
    bus.start = 1'b1; bus.op = 1'b1; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_reset_busy", {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset", 9'b0);
    @(posedge clk); #1;
    prev_op = 1'b0;
    run_op("post_reset", 1'b0, 32'd11, 0, 0, 1'b0, 34, K_WB);

    for (int i = 0; i < 16; i++) begin
      op  = 1'($urandom_range(0, 1));
      dv  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 36) : 0;
      mrz = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 36) : 0;
      model(op, dv, ab, mrz, e, kind);
      run_op($sformatf("rnd%0d", i), op, dv, ab, mrz, 1'($urandom_range(0, 1)), e, kind);
    end

    @(negedge clk);
    check("final_idle", {4'b0000, prev_op, 4'b0000});
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
